alu_arbiter: RTL and testbench
==============================

Name: alu_arbiter

Overview:
- Shares the single 32-bit ALU between N_REQ requesters, e.g. the execute stage and a branch/address-compare unit.
- Each requester presents one operation: operands A, B and the 3-bit ALU control code.
- The arbiter picks one operation per cycle by round-robin and drives it onto the ALU's combinational inputs.
- It registers the ALU's Result and flags into a one-entry response buffer, tagged with the requester id, and returns them via a valid/ready handshake.

Parameters:
- N_REQ, 2: number of requesters, from 2 to 8.
- ID_W, $clog2(N_REQ): width of the response id.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  N_REQ  per-requester operation valid.
- req_ready  out  N_REQ  per-requester accept; at most one bit high.
- req_a  in  32*N_REQ  operand A; requester i occupies bits [32i+31:32i].
- req_b  in  32*N_REQ  operand B, packed the same way.
- req_ctrl  in  3*N_REQ  ALUControl code per requester.
- alu_a  out  32  to ALU input A.
- alu_b  out  32  to ALU input B.
- alu_ctrl  out  3  to ALU ALUControl.
- alu_result  in  32  from ALU Result.
- alu_flags  in  4  from ALU {Carry, OverFlow, Zero, Negative}.
- resp_valid  out  1  response buffer full.
- resp_ready  in  1  consumer accepts the response.
- resp_result  out  32  registered ALU Result.
- resp_flags  out  4  registered ALU flags.
- resp_id  out  ID_W  index of the requester that issued the operation.

Behaviour:
- Clock and reset:
  - One clock, clk. Reset rst is synchronous and active-high.
  - At reset: resp_valid=0, resp_result=0, resp_flags=0, resp_id=0, round-robin pointer=0 (requester 0 has highest priority), FSM=EMPTY.
- FSM states:
  - EMPTY: response buffer free.
  - FULL: response buffer holds an unconsumed response.
- slot_free = (state==EMPTY) | resp_ready.
- Grant:
  - Combinational search over req_valid, starting at the pointer and wrapping modulo N_REQ.
  - The first valid requester wins. req_ready[win] = slot_free; all other req_ready bits are 0.
- Handshake: req_valid[i] & req_ready[i] in the same cycle. On a handshake:
  - alu_a/alu_b/alu_ctrl carry requester i's fields during that cycle.
  - alu_result/alu_flags are captured at the clock edge into resp_result/resp_flags, with resp_id=i.
  - resp_valid=1 next cycle; latency is exactly 1 cycle.
  - Pointer becomes (i+1) mod N_REQ.
- With no handshake: alu_a=0, alu_b=0, alu_ctrl=3'b000. The pointer does not move.
- Transitions:
  - EMPTY: handshake -> FULL; otherwise stay.
  - FULL with resp_ready: handshake -> FULL with new data; no handshake -> EMPTY.
  - FULL without resp_ready: stay, response outputs held stable, all req_ready=0.
- Throughput: 1 operation/cycle while resp_ready stays high.
- Requester rules:
  - Fields must stay stable while req_valid=1 and ready=0.
  - A requester must not drop req_valid before its handshake. The arbiter does not check this.
- Fairness: under continuous contention, requesters are granted strictly in rotation 0,1,...,N_REQ-1,0.
- Reset mid-operation: an in-flight handshake is discarded and the buffered response is lost. Outputs return to reset values on the next edge.
- Flags are passed through unmodified. The arbiter does no arithmetic.

Optional Feature:
- Macro: ALU_ARB_LOCK_EN.
- When defined:
  - Adds input req_lock (N_REQ).
  - A handshake with req_lock[i]=1 locks the arbiter to i. While locked, only requester i can receive ready, for multi-op sequences such as 64-bit add/sub.
  - The lock clears on i's next handshake with req_lock[i]=0. The pointer advances only at that release.
  - rst clears the lock.
- When undefined: the port is absent and behaviour is pure round-robin.

Decomposition:
- Package alu_arb_pkg holds:
  - the ALUControl encodings: ADD=3'b000, SUB=3'b001, AND=3'b010, OR=3'b011, SLT=3'b101, LUI=3'b111;
  - FLAG_W=4 and the flag bit positions;
  - the FSM state enum {EMPTY, FULL}.
- One sub-module: rr_pick, a combinational round-robin priority picker (req vector, pointer -> one-hot grant, index, any).

Test Plan:
- Single request: req0 A=5, B=3, ctrl=000, ALU model attached, resp_ready=1 -> next cycle resp_valid=1, result=8, id=0, flags Z=0 N=0.
- Contention: both requesters valid continuously, ctrl=001, resp_ready=1 -> grants alternate 0,1,0,1; one response every cycle. Req1 A=B=7 gives result 0 with Z=1.
- Backpressure: resp_ready=0 while FULL holding result 0xFFFFFFFF -> all req_ready=0, response held for 5 cycles. Release -> the pending request issues in the same cycle the old response drains.
- Reset mid-stream: assert rst while FULL with a handshake active -> next cycle resp_valid=0, outputs zero, pointer=0. First post-reset grant with both valid goes to req0.
- Idle: no req_valid for 10 cycles -> alu_a=alu_b=0, alu_ctrl=000, pointer unchanged.
- (ALU_ARB_LOCK_EN) Locked sequence: req1 issues two ops with lock=1 then one with lock=0, req0 continuously valid -> req1 granted 3 consecutive times, then req0.

Source files
------------

// File: rtl/alu_arb_pkg.sv
// rtl/alu_arb_pkg.sv - shared encodings and FSM state for the ALU arbiter
package alu_arb_pkg;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;
    localparam logic [2:0] ALU_LUI = 3'b111;

    // flags vector is {Carry, OverFlow, Zero, Negative}
    localparam int FLAG_W = 4;
    localparam int FLAG_C = 3;
    localparam int FLAG_V = 2;
    localparam int FLAG_Z = 1;
    localparam int FLAG_N = 0;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } arb_state_t;

endpackage

// File: rtl/alu_arbiter_rr_pick.sv
// rtl/alu_arbiter_rr_pick.sv - combinational round-robin picker starting at ptr
module rr_pick
    import alu_arb_pkg::*;
#(
    parameter int N = 2,
    parameter int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [N-1:0] grant,
    output logic [W-1:0] idx,
    output logic         any
);

    int j;

    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        j     = 0;
        for (int k = 0; k < N; k++) begin
            j = (int'(ptr) + k) % N;
            if (!any && req[j]) begin
                any      = 1'b1;
                grant[j] = 1'b1;
                idx      = W'(j);
            end
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin share of one ALU with a one-entry response buffer (option: ALU_ARB_LOCK_EN)
module alu_arbiter
    import alu_arb_pkg::*;
#(
    parameter int N_REQ = 2,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_REQ-1:0]      req_valid,
    output logic [N_REQ-1:0]      req_ready,
    input  logic [32*N_REQ-1:0]   req_a,
    input  logic [32*N_REQ-1:0]   req_b,
    input  logic [3*N_REQ-1:0]    req_ctrl,
`ifdef ALU_ARB_LOCK_EN
    input  logic [N_REQ-1:0]      req_lock,
`endif
    output logic [31:0]           alu_a,
    output logic [31:0]           alu_b,
    output logic [2:0]            alu_ctrl,
    input  logic [31:0]           alu_result,
    input  logic [FLAG_W-1:0]     alu_flags,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [31:0]           resp_result,
    output logic [FLAG_W-1:0]     resp_flags,
    output logic [ID_W-1:0]       resp_id
);

    arb_state_t        state_q, state_d;
    logic [ID_W-1:0]   ptr_q;
    logic [ID_W-1:0]   ptr_next;
    logic [N_REQ-1:0]  pick_req;
    logic [N_REQ-1:0]  grant;
    logic [ID_W-1:0]   win;
    logic              any;
    logic              slot_free;
    logic              hs;

`ifdef ALU_ARB_LOCK_EN
    logic              locked_q;
    logic [ID_W-1:0]   lock_id_q;

    // while locked only the lock owner is visible to the picker
    always_comb begin
        pick_req = req_valid;
        if (locked_q) begin
            pick_req = req_valid & (N_REQ'(1) << lock_id_q);
        end
    end
`else
    assign pick_req = req_valid;
`endif

    rr_pick #(.N(N_REQ), .W(ID_W)) u_pick (
        .req   (pick_req),
        .ptr   (ptr_q),
        .grant (grant),
        .idx   (win),
        .any   (any)
    );

    assign slot_free  = (state_q == EMPTY) | resp_ready;
    assign req_ready  = grant & {N_REQ{slot_free}};
    assign hs         = any & slot_free;
    assign ptr_next   = (int'(win) == N_REQ - 1) ? '0 : win + 1'b1;
    assign resp_valid = (state_q == FULL);

    // req_ready is one-hot and only set on a handshake, so it selects the operands
    always_comb begin
        alu_a    = '0;
        alu_b    = '0;
        alu_ctrl = ALU_ADD;
        for (int i = 0; i < N_REQ; i++) begin
            if (req_ready[i]) begin
                alu_a    = req_a[32*i +: 32];
                alu_b    = req_b[32*i +: 32];
                alu_ctrl = req_ctrl[3*i +: 3];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY:   if (hs) state_d = FULL;
            FULL:    if (resp_ready) state_d = hs ? FULL : EMPTY;
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= EMPTY;
            ptr_q       <= '0;
            resp_result <= '0;
            resp_flags  <= '0;
            resp_id     <= '0;
`ifdef ALU_ARB_LOCK_EN
            locked_q    <= 1'b0;
            lock_id_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            if (hs) begin
                resp_result <= alu_result;
                resp_flags  <= alu_flags;
                resp_id     <= win;
`ifdef ALU_ARB_LOCK_EN
                if (req_lock[win]) begin
                    locked_q  <= 1'b1;
                    lock_id_q <= win;
                end else begin
                    locked_q  <= 1'b0;
                    ptr_q     <= ptr_next;
                end
`else
                ptr_q <= ptr_next;
`endif
            end
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - directed self-checking bench for alu_arbiter with a behavioural ALU
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [63:0] req_a;
    logic [63:0] req_b;
    logic [5:0]  req_ctrl;
    logic [1:0]  req_lock;
    logic [31:0] alu_a, alu_b;
    logic [2:0]  alu_ctrl;
    logic [31:0] alu_result;
    logic [3:0]  alu_flags;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_result;
    logic [3:0]  resp_flags;
    logic [0:0]  resp_id;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.N_REQ(2), .ID_W(1)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_a       (req_a),
        .req_b       (req_b),
        .req_ctrl    (req_ctrl),
`ifdef ALU_ARB_LOCK_EN
        .req_lock    (req_lock),
`endif
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_ctrl    (alu_ctrl),
        .alu_result  (alu_result),
        .alu_flags   (alu_flags),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_result (resp_result),
        .resp_flags  (resp_flags),
        .resp_id     (resp_id)
    );

    // behavioural ALU, flags = {C, V, Z, N}
    logic [32:0] sum;
    always_comb begin
        sum = '0;
        alu_result = '0;
        alu_flags  = '0;
        case (alu_ctrl)
            3'b000: sum = {1'b0, alu_a} + {1'b0, alu_b};
            3'b001: sum = {1'b0, alu_a} + {1'b0, ~alu_b} + 33'd1;
            3'b010: sum = {1'b0, alu_a & alu_b};
            3'b011: sum = {1'b0, alu_a | alu_b};
            3'b101: sum = {32'd0, $signed(alu_a) < $signed(alu_b)};
            3'b111: sum = {1'b0, alu_b[19:0], 12'd0};
            default: sum = '0;
        endcase
        alu_result   = sum[31:0];
        alu_flags[3] = sum[32];
        alu_flags[2] = (alu_ctrl == 3'b000) ? (alu_a[31] == alu_b[31]) && (sum[31] != alu_a[31]) :
                       (alu_ctrl == 3'b001) ? (alu_a[31] != alu_b[31]) && (sum[31] != alu_a[31]) : 1'b0;
        alu_flags[1] = (sum[31:0] == 32'd0);
        alu_flags[0] = sum[31];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        rst        = 1'b1;
        req_valid  = '0;
        req_a      = '0;
        req_b      = '0;
        req_ctrl   = '0;
        req_lock   = '0;
        resp_ready = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        settle();
        chk("rst_valid",  32'(resp_valid), 32'd0);
        chk("rst_result", resp_result, 32'd0);
        chk("rst_flags",  32'(resp_flags), 32'd0);
        chk("rst_id",     32'(resp_id), 32'd0);
        chk("rst_ready",  32'(req_ready), 32'd0);

        // single request 5 + 3
        req_a[31:0] = 32'd5; req_b[31:0] = 32'd3; req_ctrl[2:0] = 3'b000;
        req_valid = 2'b01;
        settle();
        chk("single_ready", 32'(req_ready), 32'd1);
        chk("single_alu_a", alu_a, 32'd5);
        tick();
        req_valid = 2'b00;
        chk("single_valid",  32'(resp_valid), 32'd1);
        chk("single_result", resp_result, 32'd8);
        chk("single_id",     32'(resp_id), 32'd0);
        chk("single_flags",  32'(resp_flags), 32'b0000);
        tick();
        chk("drain_empty", 32'(resp_valid), 32'd0);

        // contention on SUB; pointer is at 1 after the single op
        req_a[31:0]  = 32'd10; req_b[31:0]  = 32'd4; req_ctrl[2:0] = 3'b001;
        req_a[63:32] = 32'd7;  req_b[63:32] = 32'd7; req_ctrl[5:3] = 3'b001;
        req_valid = 2'b11;
        for (int k = 0; k < 4; k++) begin
            settle();
            chk("cont_ready", 32'(req_ready), (k % 2 == 0) ? 32'd2 : 32'd1);
            tick();
            chk("cont_valid", 32'(resp_valid), 32'd1);
            chk("cont_id", 32'(resp_id), (k % 2 == 0) ? 32'd1 : 32'd0);
            chk("cont_result", resp_result, (k % 2 == 0) ? 32'd0 : 32'd6);
            chk("cont_flags", 32'(resp_flags), (k % 2 == 0) ? 32'b1010 : 32'b1000);
        end
        req_valid = 2'b00;

        // backpressure: buffer holds 0 - 1
        req_a[63:32] = 32'd0; req_b[63:32] = 32'd1;
        req_valid = 2'b10;
        tick();
        resp_ready = 1'b0;
        req_valid  = 2'b01;
        chk("bp_result", resp_result, 32'hFFFF_FFFF);
        chk("bp_flags",  32'(resp_flags), 32'b0001);
        chk("bp_id",     32'(resp_id), 32'd1);
        for (int k = 0; k < 5; k++) begin
            settle();
            chk("bp_ready", 32'(req_ready), 32'd0);
            chk("bp_alu_a", alu_a, 32'd0);
            tick();
            chk("bp_hold_valid",  32'(resp_valid), 32'd1);
            chk("bp_hold_result", resp_result, 32'hFFFF_FFFF);
        end
        resp_ready = 1'b1;
        settle();
        chk("bp_release_ready", 32'(req_ready), 32'd1);
        chk("bp_release_alu_a", alu_a, 32'd10);
        tick();
        req_valid = 2'b00;
        chk("bp_new_result", resp_result, 32'd6);
        chk("bp_new_id",     32'(resp_id), 32'd0);

        // reset while FULL with a handshake in flight (req1 would win)
        req_valid = 2'b11;
        req_a[63:32] = 32'd7; req_b[63:32] = 32'd7;
        settle();
        chk("rstmid_pre_ready", 32'(req_ready), 32'd2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rstmid_valid",  32'(resp_valid), 32'd0);
        chk("rstmid_result", resp_result, 32'd0);
        chk("rstmid_flags",  32'(resp_flags), 32'd0);
        chk("rstmid_id",     32'(resp_id), 32'd0);
        settle();
        chk("rstmid_grant0", 32'(req_ready), 32'd1);
        tick();
        req_valid = 2'b00;
        chk("rstmid_first_id",     32'(resp_id), 32'd0);
        chk("rstmid_first_result", resp_result, 32'd6);

        // idle: pointer stays at 1
        for (int k = 0; k < 10; k++) begin
            tick();
            chk("idle_alu", alu_a | alu_b | 32'(alu_ctrl), 32'd0);
            chk("idle_ready", 32'(req_ready), 32'd0);
        end
        chk("idle_empty", 32'(resp_valid), 32'd0);
        req_valid = 2'b11;
        settle();
        chk("idle_ptr_kept", 32'(req_ready), 32'd2);
        tick();
        req_valid = 2'b00;
        chk("idle_after_id", 32'(resp_id), 32'd1);

`ifdef ALU_ARB_LOCK_EN
        // pointer is 0; req1 locks, req0 contends, req1 keeps the grant until release
        req_valid = 2'b10; req_lock = 2'b10;
        settle();
        chk("lock_g1", 32'(req_ready), 32'd2);
        tick();
        req_valid = 2'b11;
        settle();
        chk("lock_g2", 32'(req_ready), 32'd2);
        tick();
        req_lock = 2'b00;
        settle();
        chk("lock_g3", 32'(req_ready), 32'd2);
        tick();
        chk("lock_g3_id", 32'(resp_id), 32'd1);
        settle();
        chk("lock_after", 32'(req_ready), 32'd1);
        tick();
        req_valid = 2'b00;
        chk("lock_after_id", 32'(resp_id), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
